pmem_line_responder: RTL



---
 rtl/pmem_line_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pmem_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : pmem_line_responder
// Purpose  : Line-granular backing store answering the cache pmem interface.
//            One 128-bit read or write at a time, one-cycle pmem_resp after a
//            fixed LATENCY, protocol-violation pulses and access counters.
// Revision : 1.0 - initial release
// ============================================================================
module pmem_line_responder #(
  parameter int LATENCY   = 10,
  parameter int LINE_BITS = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         pmem_error,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  localparam int         C_DEPTH  = 1 << LINE_BITS;
  localparam logic [7:0] C_LOAD   = 8'(LATENCY - 1);
  localparam bit         C_DIRECT = (LATENCY == 1);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_WAIT = 2'd1;
  localparam logic [1:0] C_RESP = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [7:0]           r_cnt;
  logic                 r_op_write;
  logic [LINE_BITS-1:0] r_idx;
  logic [127:0]         r_wdata;
  logic [127:0]         r_mem [C_DEPTH];

  logic                 w_req_one;
  logic                 w_req_both;
  logic                 w_req_none;
  logic                 w_accept;
  logic                 w_abort;
  logic                 w_enter_resp;
  logic                 w_sel_write;
  logic [LINE_BITS-1:0] w_sel_idx;
  logic [127:0]         w_sel_wdata;
  logic [LINE_BITS-1:0] w_idx_in;
  logic                 w_mem_we;
  logic                 w_rd_load;
  logic                 w_unused;

  // Low nibble and any bits above the line index only alias; they are never stored.
  assign w_unused   = ^pmem_address;

  assign w_idx_in   = pmem_address[LINE_BITS+3:4];
  assign w_req_one  = pmem_read ^ pmem_write;
  assign w_req_both = pmem_read & pmem_write;
  assign w_req_none = ~(pmem_read | pmem_write);
  assign w_accept   = (r_state == C_IDLE) & w_req_one;
  assign w_abort    = (r_state == C_WAIT) & w_req_none;

  // With LATENCY=1 the request goes straight from IDLE to RESP, so the memory
  // access must use the live inputs instead of the (not yet loaded) capture.
  assign w_enter_resp = (w_accept & C_DIRECT)
                      | ((r_state == C_WAIT) & ~w_req_none & (r_cnt == 8'd1));
  assign w_sel_write  = (r_state == C_IDLE) ? pmem_write : r_op_write;
  assign w_sel_idx    = (r_state == C_IDLE) ? w_idx_in   : r_idx;
  assign w_sel_wdata  = (r_state == C_IDLE) ? pmem_wdata : r_wdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= C_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decision
  always_comb begin
    w_next = r_state;
    case (r_state)
      C_IDLE: if (w_accept) w_next = C_DIRECT ? C_RESP : C_WAIT;
      C_WAIT: begin
        if (w_abort)           w_next = C_IDLE;
        else if (w_enter_resp) w_next = C_RESP;
      end
      C_RESP:  w_next = C_IDLE;
      default: w_next = C_IDLE;
    endcase
  end

  // Output and strobe decode; memory strobes are blocked while reset is held
  always_comb begin
    pmem_resp = (r_state == C_RESP);
    w_mem_we  = w_enter_resp & w_sel_write & rst_n;
    w_rd_load = w_enter_resp & ~w_sel_write;
  end

  // Request capture and latency countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_op_write <= pmem_write;
      r_idx      <= w_idx_in;
      r_wdata    <= pmem_wdata;
      r_cnt      <= C_LOAD;
    end else if (r_state == C_WAIT) begin
      r_cnt      <= r_cnt - 8'd1;
    end
  end

  // Line storage: no reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_sel_idx] <= w_sel_wdata;
  end

  // Read data register, holds until the next completed read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pmem_rdata <= '0;
    else if (w_rd_load) pmem_rdata <= r_mem[w_sel_idx];
  end

  // Protocol-violation pulse: conflicting ops in IDLE or request dropped in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pmem_error <= 1'b0;
    else        pmem_error <= ((r_state == C_IDLE) & w_req_both) | w_abort;
  end

  // Completion counters, bumped on the edge that leaves RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (r_state == C_RESP) begin
      if (r_op_write) wr_count <= wr_count + 16'd1;
      else            rd_count <= rd_count + 16'd1;
    end
  end

endmodule
`default_nettype wire
